// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the register file: zero-fills after reset, then
// round-robin arbitrates A/B writebacks. Optional stall counter via RF_ARB_STALL_CNT_EN.
module regfile_write_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
`ifdef RF_ARB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam state_t            LP_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
    localparam logic [ADDR_W-1:0] LP_LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LP_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LP_ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] LP_ZERO_DATA = {DATA_W{1'b0}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_rr_ptr;       // 0: A has priority on contention, 1: B
    logic              w_rr_ptr_nxt;
    logic              w_a_grant;
    logic              w_b_grant;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;

    // State, fill index and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LP_RST_STATE;
            r_clr_idx <= LP_ZERO_ADDR;
            r_rr_ptr  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // Next-state, grant selection and next write-port values
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_a_grant     = 1'b0;
        w_b_grant     = 1'b0;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        case (r_state)
            ST_CLEAR: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_clr_idx;
                w_wdata_nxt = LP_ZERO_DATA;
                if (r_clr_idx == LP_LAST_IDX) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + LP_ONE;
                end
            end
            ST_ARB: begin
                if (a_valid && b_valid) begin
                    w_a_grant    = ~r_rr_ptr;
                    w_b_grant    = r_rr_ptr;
                    w_rr_ptr_nxt = ~r_rr_ptr;
                end else begin
                    w_a_grant = a_valid;
                    w_b_grant = b_valid;
                end
                // x0 writes are accepted but never reach the register file
                if (w_a_grant) begin
                    w_we_nxt    = (a_addr != LP_ZERO_ADDR);
                    w_waddr_nxt = a_addr;
                    w_wdata_nxt = a_data;
                end else if (w_b_grant) begin
                    w_we_nxt    = (b_addr != LP_ZERO_ADDR);
                    w_waddr_nxt = b_addr;
                    w_wdata_nxt = b_data;
                end else begin
                    w_we_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = LP_RST_STATE;
            end
        endcase
    end

    // Registered write port toward the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= LP_ZERO_ADDR;
            r_wdata <= LP_ZERO_DATA;
        end else begin
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign a_ready   = w_a_grant;
    assign b_ready   = w_b_grant;
    assign init_done = (r_state == ST_ARB);

`ifdef RF_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == ST_ARB) &&
                     ((a_valid && !w_a_grant) || (b_valid && !w_b_grant));

    // Saturating count of ARB cycles where some requester was held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a
// transaction-level model (grant order, shadow register file, stall count).
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
`ifdef RF_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
`ifdef RF_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] tb_rf  [32];
    logic [31:0] exp_rf [32];
    logic        turn_b;
    logic [31:0] exp_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file downstream of the write port
    always @(posedge clk) begin
        if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One ARB cycle: model decides the winner, readies checked mid-cycle,
    // registered write port checked just after the edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        output logic ga, output logic gb);
        logic        ega, egb;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        if (av && bv) begin
            ega = !turn_b;
            egb = turn_b;
        end else begin
            ega = av;
            egb = bv;
        end
        chk_val("a_ready", {31'd0, a_ready}, {31'd0, ega});
        chk_val("b_ready", {31'd0, b_ready}, {31'd0, egb});
        @(posedge clk);
        #1;
        if (ega || egb) begin
            waddr = ega ? aa : ba;
            wdata = ega ? ad : bd;
            chk_val("rf_we", {31'd0, rf_we}, {31'd0, (waddr != 5'd0)});
            chk_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, waddr});
            chk_val("rf_wdata", rf_wdata, wdata);
            if (waddr != 5'd0) exp_rf[waddr] = wdata;
        end else begin
            chk_val("rf_we_idle", {31'd0, rf_we}, 32'd0);
        end
        if (av && bv) begin
            turn_b    = !turn_b;
            exp_stall = exp_stall + 32'd1;
        end
`ifdef RF_ARB_STALL_CNT_EN
        chk_val("stall_cnt", stall_cnt, exp_stall);
`endif
        ga = ega;
        gb = egb;
    endtask

    // Full zero-fill after a release; requesters hold valid to prove no early accept
    task automatic clear_check();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2222_2222;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            chk_val("clr_we", {31'd0, rf_we}, 32'd1);
            chk_val("clr_waddr", {27'd0, rf_waddr}, i);
            chk_val("clr_wdata", rf_wdata, 32'd0);
            chk_val("clr_init_done", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) begin
                chk_val("clr_a_ready", {31'd0, a_ready}, 32'd0);
                chk_val("clr_b_ready", {31'd0, b_ready}, 32'd0);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int r = 0; r < 32; r++) exp_rf[r] = 32'd0;
    endtask

    initial begin
        logic        ga, gb;
        logic        pav, pbv;
        logic [4:0]  paa, pba;
        logic [31:0] pad, pbd;
        logic [31:0] st0;

        rst_n = 1'b0;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        turn_b = 1'b0;
        exp_stall = 32'd0;
        #12;
        chk_val("rst_we", {31'd0, rf_we}, 32'd0);
        chk_val("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk_val("rst_wdata", rf_wdata, 32'd0);
        chk_val("rst_init_done", {31'd0, init_done}, 32'd0);

        // Abort the first fill at index 10
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_val("pre_clr_we", {31'd0, rf_we}, 32'd0);
        repeat (11) @(posedge clk);
        #1;
        chk_val("mid_waddr", {27'd0, rf_waddr}, 32'd10);
        rst_n = 1'b0;
        #1;
        chk_val("abort_we", {31'd0, rf_we}, 32'd0);
        chk_val("abort_waddr", {27'd0, rf_waddr}, 32'd0);
        chk_val("abort_init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        turn_b = 1'b0;
        exp_stall = 32'd0;
        clear_check();
`ifdef RF_ARB_STALL_CNT_EN
        chk_val("stall_after_clr", stall_cnt, 32'd0);
`endif

        // A alone
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, ga, gb);

        // Four contended cycles starting with A priority: A,B,A,B
        st0 = exp_stall;
        for (int i = 0; i < 4; i++) begin
            step(!ga || i == 0 ? 1'b1 : 1'b1, 5'd9, 32'hA000_0009,
                 1'b1, 5'd10, 32'hB000_000A, ga, gb);
            chk_val("t4_order_a", {31'd0, ga}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk_val("t4_stall_delta", exp_stall - st0, 32'd4);

        // B write to x0 is accepted but suppressed
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, ga, gb);
        chk_val("x0_b_grant", {31'd0, gb}, 32'd1);

        // Move priority to B, then same-address collision on x7
        step(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, ga, gb);
        step(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, ga, gb);
        chk_val("t6_b_first", {31'd0, gb}, 32'd1);
        step(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, ga, gb);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        chk_val("x7_value", tb_rf[7], 32'd1);
        chk_val("x0_value", tb_rf[0], 32'd0);

        // Random traffic; a requester keeps its request until it is accepted
        pav = 1'b0; pbv = 1'b0;
        paa = 5'd0; pba = 5'd0; pad = 32'd0; pbd = 32'd0;
        for (int n = 0; n < 400; n++) begin
            if (!pav) begin
                pav = 1'($urandom_range(0, 1));
                paa = 5'($urandom);
                pad = $urandom;
            end
            if (!pbv) begin
                pbv = 1'($urandom_range(0, 1));
                pba = 5'($urandom);
                pbd = $urandom;
            end
            step(pav, paa, pad, pbv, pba, pbd, ga, gb);
            if (ga) pav = 1'b0;
            if (gb) pbv = 1'b0;
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        for (int r = 0; r < 32; r++) begin
            chk_val($sformatf("rf_x%0d", r), tb_rf[r], exp_rf[r]);
        end
        chk_val("init_done_hold", {31'd0, init_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
